// File: rtl/instr_fetcher.sv
// Instruction fetch stage: reads the instruction at current_pc from program memory over a
// valid/ready channel, with an optional single-entry last-fetch buffer for repeated PCs.
module instr_fetcher #(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned BUFFER_EN             = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      fetch_count
);

    localparam logic [2:0] CoreFetch  = 3'b001;
    localparam logic [2:0] CoreDecode = 3'b010;

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StFetching = 3'b001,
        StFetched  = 3'b010
    } state_e;

    state_e                             state_q;
    logic                               buf_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_pc_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data_q;
    logic                               buf_hit;

    assign buf_hit       = (BUFFER_EN != 0) && buf_valid_q && (buf_pc_q == current_pc);
    assign fetcher_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            fetch_count      <= '0;
            buf_valid_q      <= 1'b0;
            buf_pc_q         <= '0;
            buf_data_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (core_state == CoreFetch) begin
                        if (buf_hit) begin
                            instruction <= buf_data_q;
                            state_q     <= StFetched;
                        end else begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= current_pc;
                            state_q          <= StFetching;
                        end
                    end
                end
                // Request is held until ready; pc and core_state changes are ignored here.
                StFetching: begin
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        buf_valid_q    <= 1'b1;
                        buf_pc_q       <= mem_read_address;
                        buf_data_q     <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state_q        <= StFetched;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end
                end
                StFetched: begin
                    if (core_state == CoreDecode) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: one instance with the last-fetch buffer, one without.
module tb_instr_fetcher;

    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;
    localparam logic [2:0] CS_OTHER  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [2:0]  core_state = 3'b000;
    logic [7:0]  current_pc = '0;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = '0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] fetch_count;

    logic [2:0]  cs_nb = 3'b000;
    logic [7:0]  pc_nb = '0;
    logic        rdy_nb = 1'b0;
    logic [15:0] data_nb = '0;
    logic        valid_nb;
    logic [7:0]  addr_nb;
    logic [2:0]  state_nb;
    logic [15:0] instr_nb;
    logic [15:0] count_nb;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_nb_q[$];

    always #5 clk = ~clk;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .BUFFER_EN(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .fetch_count(fetch_count)
    );

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .BUFFER_EN(0)
    ) dut_nb (
        .clk(clk),
        .reset(reset),
        .core_state(cs_nb),
        .current_pc(pc_nb),
        .mem_read_valid(valid_nb),
        .mem_read_address(addr_nb),
        .mem_read_ready(rdy_nb),
        .mem_read_data(data_nb),
        .fetcher_state(state_nb),
        .instruction(instr_nb),
        .fetch_count(count_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare {instruction, fetch_count} whenever a DUT enters FETCHED.
    logic [2:0] prev_state = 3'b000;
    always @(negedge clk) begin
        if (fetcher_state == 3'b010 && prev_state != 3'b010) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetched", 32'd1, 32'd0);
            end else begin
                check("sb_result", {instruction, fetch_count}, exp_q.pop_front());
            end
        end
        prev_state <= fetcher_state;
    end

    logic [2:0] prev_nb = 3'b000;
    always @(negedge clk) begin
        if (state_nb == 3'b010 && prev_nb != 3'b010) begin
            if (exp_nb_q.size() == 0) begin
                check("unexpected_fetched_nb", 32'd1, 32'd0);
            end else begin
                check("sb_result_nb", {instr_nb, count_nb}, exp_nb_q.pop_front());
            end
        end
        prev_nb <= state_nb;
    end

    // Miss: valid is high for 'lat' cycles, ready is given in the last of them.
    task automatic fetch_mem(input logic [7:0] pc, input logic [15:0] data, input int lat,
                             input logic [15:0] exp_cnt);
        current_pc = pc;
        core_state = CS_FETCH;
        tick();
        check("miss_valid", {31'd0, mem_read_valid}, 32'd1);
        check("miss_addr", {24'd0, mem_read_address}, {24'd0, pc});
        check("miss_state", {29'd0, fetcher_state}, 32'd1);
        core_state = CS_OTHER;
        for (int i = 1; i < lat; i++) begin
            tick();
            check("hold_valid", {31'd0, mem_read_valid}, 32'd1);
            check("hold_addr", {24'd0, mem_read_address}, {24'd0, pc});
        end
        mem_read_ready = 1'b1;
        mem_read_data = data;
        exp_q.push_back({data, exp_cnt});
        tick();
        mem_read_ready = 1'b0;
        check("done_valid", {31'd0, mem_read_valid}, 32'd0);
        core_state = CS_DECODE;
        tick();
        check("decode_idle", {29'd0, fetcher_state}, 32'd0);
        core_state = 3'b000;
    endtask

    task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] exp_instr,
                             input logic [15:0] exp_cnt);
        current_pc = pc;
        core_state = CS_FETCH;
        exp_q.push_back({exp_instr, exp_cnt});
        tick();
        check("hit_no_valid", {31'd0, mem_read_valid}, 32'd0);
        check("hit_state", {29'd0, fetcher_state}, 32'd2);
        core_state = CS_DECODE;
        tick();
        check("hit_idle", {29'd0, fetcher_state}, 32'd0);
        core_state = 3'b000;
    endtask

    task automatic fetch_nb(input logic [15:0] data, input logic [15:0] exp_cnt);
        pc_nb = 8'h00;
        cs_nb = CS_FETCH;
        tick();
        check("nb_valid", {31'd0, valid_nb}, 32'd1);
        check("nb_addr", {24'd0, addr_nb}, 32'd0);
        cs_nb = 3'b000;
        rdy_nb = 1'b1;
        data_nb = data;
        exp_nb_q.push_back({data, exp_cnt});
        tick();
        rdy_nb = 1'b0;
        cs_nb = CS_DECODE;
        tick();
        check("nb_idle", {29'd0, state_nb}, 32'd0);
        cs_nb = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_state", {29'd0, fetcher_state}, 32'd0);
        check("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        check("rst_addr", {24'd0, mem_read_address}, 32'd0);
        check("rst_instr", {16'd0, instruction}, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: miss with three cycles of valid
        fetch_mem(8'h05, 16'h3A17, 3, 16'd1);
        // 2: buffer hit, then a different pc misses
        fetch_hit(8'h05, 16'h3A17, 16'd1);
        check("hit_count", {16'd0, fetch_count}, 32'd1);
        fetch_mem(8'h06, 16'h1234, 2, 16'd2);
        // 3: ready in the cycle valid rises; stray ready while idle
        fetch_mem(8'h30, 16'hBEEF, 1, 16'd3);
        mem_read_ready = 1'b1;
        mem_read_data = 16'hDEAD;
        tick();
        tick();
        mem_read_ready = 1'b0;
        check("stray_state", {29'd0, fetcher_state}, 32'd0);
        check("stray_instr", {16'd0, instruction}, 32'h0000BEEF);
        check("stray_count", {16'd0, fetch_count}, 32'd3);

        // 4: pc and core_state changes during FETCHING are ignored
        current_pc = 8'h10;
        core_state = CS_FETCH;
        tick();
        current_pc = 8'h20;
        core_state = CS_DECODE;
        tick();
        check("chg_addr", {24'd0, mem_read_address}, 32'h10);
        check("chg_state", {29'd0, fetcher_state}, 32'd1);
        check("chg_valid", {31'd0, mem_read_valid}, 32'd1);
        mem_read_ready = 1'b1;
        mem_read_data = 16'h5555;
        exp_q.push_back({16'h5555, 16'd4});
        tick();
        mem_read_ready = 1'b0;
        tick();
        check("chg_idle", {29'd0, fetcher_state}, 32'd0);
        core_state = 3'b000;

        // 5: asynchronous reset in the middle of a fetch
        current_pc = 8'h40;
        core_state = CS_FETCH;
        tick();
        check("pre_rst_valid", {31'd0, mem_read_valid}, 32'd1);
        core_state = 3'b000;
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, mem_read_valid}, 32'd0);
        check("arst_state", {29'd0, fetcher_state}, 32'd0);
        check("arst_instr", {16'd0, instruction}, 32'd0);
        tick();
        reset = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data = 16'h7777;
        tick();
        tick();
        mem_read_ready = 1'b0;
        check("late_rdy_state", {29'd0, fetcher_state}, 32'd0);
        check("late_rdy_instr", {16'd0, instruction}, 32'd0);
        fetch_mem(8'h10, 16'h9999, 2, 16'd1);

        // 6: buffer disabled, repeated pc always misses; saturating count
        fetch_nb(16'hA001, 16'd1);
        fetch_nb(16'hA002, 16'd2);
        fetch_nb(16'hA003, 16'd3);
        force dut_nb.fetch_count = 16'hFFFF;
        tick();
        release dut_nb.fetch_count;
        tick();
        fetch_nb(16'hA004, 16'hFFFF);
        check("sat_count", {16'd0, count_nb}, 32'h0000FFFF);

        tick();
        check("sb_drained", exp_q.size(), 32'd0);
        check("sb_nb_drained", exp_nb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
